// File: rtl/prof_master_arbiter.sv
// prof_master_arbiter
//   Shares one Avalon-MM profile master port between two requesters:
//   m0 (profiler counter init/retrieve engine) and m1 (debug/host readback).
//   Round-robin arbitration with a registered grant, grant locking, and a
//   bounded hold of HOLD_MAX accepted commands while the other side waits.
//   Outstanding pipelined reads are counted so every readdatavalid returns to
//   the requester that issued the read.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   mX_read/write/address/
//     writedata/byteenable        requester X command (X = 0, 1)
//   mX_readdata                   read data, broadcast to both requesters
//   mX_waitrequest                stall to requester X
//   mX_readdatavalid              read data valid, issuing requester only
//   avm_profileMaster_*           downstream Avalon-MM master port
//   owner                         current or last grant holder
//   busy                          arbiter not idle or reads still in flight
//   err_rdv                       sticky: readdatavalid with nothing in flight
module prof_master_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int HOLD_MAX        = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_waitrequest,
  output logic                m0_readdatavalid,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_waitrequest,
  output logic                m1_readdatavalid,
  output logic                avm_profileMaster_read,
  output logic                avm_profileMaster_write,
  output logic [ADDR_W-1:0]   avm_profileMaster_address,
  output logic [DATA_W-1:0]   avm_profileMaster_writedata,
  output logic [DATA_W/8-1:0] avm_profileMaster_byteenable,
  input  logic [DATA_W-1:0]   avm_profileMaster_readdata,
  input  logic                avm_profileMaster_waitrequest,
  input  logic                avm_profileMaster_readdatavalid,
  output logic                owner,
  output logic                busy,
  output logic                err_rdv
);

  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic [OUT_W-1:0]  outstanding_q, outstanding_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              err_rdv_q, err_rdv_d;

  logic req0, req1;
  logic own_read, own_write, own_req, other_req;
  logic in_grant, block;
  logic ds_read, ds_write;
  logic accept, rd_accept, rdv_ok;
  logic nonlast_req, pick;
  logic release_grant;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign own_read  = owner_q ? m1_read  : m0_read;
  assign own_write = owner_q ? m1_write : m0_write;
  assign own_req   = own_read | own_write;
  assign other_req = owner_q ? req0 : req1;
  assign in_grant  = (state_q == GRANT);

  // Stall only reads once the return pipeline is full; writes need no slot.
  assign block     = (outstanding_q == OUT_W'(MAX_OUTSTANDING)) & own_read;
  assign ds_read   = in_grant & own_read & ~block;
  assign ds_write  = in_grant & own_write;
  assign accept    = (ds_read | ds_write) & ~avm_profileMaster_waitrequest;
  assign rd_accept = ds_read & ~avm_profileMaster_waitrequest;

  // A return with nothing in flight is an error and never reaches a requester.
  assign rdv_ok    = avm_profileMaster_readdatavalid & (outstanding_q != '0);

  // Prefer the requester that did not hold the last grant.
  assign nonlast_req = last_q ? req0 : req1;
  assign pick        = nonlast_req ? ~last_q : last_q;

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_d        = last_q;
    outstanding_d = outstanding_q;
    hold_cnt_d    = hold_cnt_q;
    err_rdv_d     = err_rdv_q | (avm_profileMaster_readdatavalid & (outstanding_q == '0));
    release_grant = 1'b0;

    // Simultaneous accept and return cancel out.
    if (rd_accept && !rdv_ok) begin
      outstanding_d = outstanding_q + OUT_W'(1);
    end else if (!rd_accept && rdv_ok) begin
      outstanding_d = outstanding_q - OUT_W'(1);
    end

    if (accept && (hold_cnt_q != HOLD_W'(HOLD_MAX))) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d    = pick;
          last_d     = pick;
          hold_cnt_d = '0;
          state_d    = GRANT;
        end
      end
      GRANT: begin
        // Hold limit uses the count including this cycle's accept, so the
        // HOLD_MAX-th command completes and the next one is not forwarded.
        release_grant = ~own_req | ((hold_cnt_d == HOLD_W'(HOLD_MAX)) & other_req);
        if (release_grant) begin
          state_d = (outstanding_d != '0) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (outstanding_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      outstanding_q <= '0;
      hold_cnt_q    <= '0;
      err_rdv_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      outstanding_q <= outstanding_d;
      hold_cnt_q    <= hold_cnt_d;
      err_rdv_q     <= err_rdv_d;
    end
  end

  assign avm_profileMaster_read       = ds_read;
  assign avm_profileMaster_write      = ds_write;
  assign avm_profileMaster_address    = owner_q ? m1_address    : m0_address;
  assign avm_profileMaster_writedata  = owner_q ? m1_writedata  : m0_writedata;
  assign avm_profileMaster_byteenable = owner_q ? m1_byteenable : m0_byteenable;

  assign m0_waitrequest = ~(in_grant & ~owner_q) | avm_profileMaster_waitrequest | block;
  assign m1_waitrequest = ~(in_grant &  owner_q) | avm_profileMaster_waitrequest | block;

  // Ownership is frozen while reads are in flight, so owner_q routes returns.
  assign m0_readdata      = avm_profileMaster_readdata;
  assign m1_readdata      = avm_profileMaster_readdata;
  assign m0_readdatavalid = rdv_ok & ~owner_q;
  assign m1_readdatavalid = rdv_ok &  owner_q;

  assign owner   = owner_q;
  assign busy    = (state_q != IDLE) | (outstanding_q != '0);
  assign err_rdv = err_rdv_q;

endmodule

// File: tb/tb_prof_master_arbiter.sv
`timescale 1ns/1ps
module tb_prof_master_arbiter;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } cmd_t;

  typedef struct packed {
    logic        m;
    logic [31:0] data;
  } rdv_t;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } pend_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        m0_read = 1'b0, m0_write = 1'b0;
  logic [31:0] m0_address = '0, m0_writedata = '0;
  logic [3:0]  m0_byteenable = '0;
  logic [31:0] m0_readdata;
  logic        m0_waitrequest, m0_readdatavalid;
  logic        m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m1_address = '0, m1_writedata = '0;
  logic [3:0]  m1_byteenable = '0;
  logic [31:0] m1_readdata;
  logic        m1_waitrequest, m1_readdatavalid;
  logic        avm_read, avm_write;
  logic [31:0] avm_address, avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0, avm_readdatavalid = 1'b0;
  logic        owner, busy, err_rdv;

  prof_master_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4), .HOLD_MAX(8)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
    .m1_readdatavalid(m1_readdatavalid),
    .avm_profileMaster_read(avm_read), .avm_profileMaster_write(avm_write),
    .avm_profileMaster_address(avm_address),
    .avm_profileMaster_writedata(avm_writedata),
    .avm_profileMaster_byteenable(avm_byteenable),
    .avm_profileMaster_readdata(avm_readdata),
    .avm_profileMaster_waitrequest(avm_waitrequest),
    .avm_profileMaster_readdatavalid(avm_readdatavalid),
    .owner(owner), .busy(busy), .err_rdv(err_rdv)
  );

  always #5 clk = ~clk;

  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;
  int    acc_cnt = 0;
  int    last_acc_cyc = 0;
  int    last_rdv_cyc = 0;
  bit    slave_hold = 1'b0;
  bit    slave_stall = 1'b0;
  bit    inject_rdv = 1'b0;
  int    slave_lat = 2;

  cmd_t  m0_cmds[$];
  cmd_t  m1_cmds[$];
  cmd_t  exp_cmd_q[$];
  rdv_t  exp_rdv_q[$];
  pend_t pend_q[$];

  function automatic logic [31:0] rd_val(input logic [31:0] addr);
    return addr ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got unexpected event expected none (cycle %0d)", name, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Requester models: hold the front command until accepted.
  initial forever begin
    bit acc;
    @(negedge clk);
    acc = (m0_read | m0_write) & ~m0_waitrequest;
    @(posedge clk); #1;
    if (acc && m0_cmds.size() > 0) void'(m0_cmds.pop_front());
    if (m0_cmds.size() > 0) begin
      m0_read = ~m0_cmds[0].wr; m0_write = m0_cmds[0].wr;
      m0_address = m0_cmds[0].addr; m0_writedata = m0_cmds[0].data;
      m0_byteenable = m0_cmds[0].be;
    end else begin
      m0_read = 1'b0; m0_write = 1'b0;
    end
  end

  initial forever begin
    bit acc;
    @(negedge clk);
    acc = (m1_read | m1_write) & ~m1_waitrequest;
    @(posedge clk); #1;
    if (acc && m1_cmds.size() > 0) void'(m1_cmds.pop_front());
    if (m1_cmds.size() > 0) begin
      m1_read = ~m1_cmds[0].wr; m1_write = m1_cmds[0].wr;
      m1_address = m1_cmds[0].addr; m1_writedata = m1_cmds[0].data;
      m1_byteenable = m1_cmds[0].be;
    end else begin
      m1_read = 1'b0; m1_write = 1'b0;
    end
  end

  // Slave model: fixed-latency in-order read returns, optional stall/hold.
  initial forever begin
    @(posedge clk); #1;
    avm_waitrequest = slave_stall & cyc[0];
    if (inject_rdv) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = 32'h0BAD_0BAD;
    end else if (!slave_hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata = rd_val(pend_q[0].addr);
      void'(pend_q.pop_front());
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
    end
  end

  // Monitor: pops expected downstream commands and read returns.
  initial forever begin
    cmd_t e;
    rdv_t r;
    @(negedge clk);
    if ((avm_read | avm_write) && !avm_waitrequest) begin
      acc_cnt++;
      last_acc_cyc = cyc;
      if (avm_read) pend_q.push_back('{addr: avm_address, due: cyc + slave_lat});
      if (exp_cmd_q.size() == 0) begin
        fail_evt("cmd_unexpected");
      end else begin
        e = exp_cmd_q.pop_front();
        check("cmd_write", avm_write, e.wr);
        check("cmd_read", avm_read, !e.wr);
        check("cmd_addr", avm_address, e.addr);
        check("cmd_be", avm_byteenable, e.be);
        if (e.wr) check("cmd_wdata", avm_writedata, e.data);
      end
    end
    if (m0_readdatavalid | m1_readdatavalid) begin
      last_rdv_cyc = cyc;
      if (exp_rdv_q.size() == 0) begin
        fail_evt("rdv_unexpected");
      end else begin
        r = exp_rdv_q.pop_front();
        check("rdv_m0", m0_readdatavalid, !r.m);
        check("rdv_m1", m1_readdatavalid, r.m);
        check("rdata_m0", m0_readdata, r.data);
        check("rdata_m1", m1_readdata, r.data);
      end
    end
  end

  task automatic issue(input bit m, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] be);
    cmd_t c;
    c = '{wr: wr, addr: addr, data: data, be: be};
    if (m) m1_cmds.push_back(c);
    else   m0_cmds.push_back(c);
  endtask

  task automatic expect_cmd(input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] be);
    exp_cmd_q.push_back('{wr: wr, addr: addr, data: data, be: be});
  endtask

  task automatic issue_exp(input bit m, input bit wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be);
    issue(m, wr, addr, data, be);
    expect_cmd(wr, addr, data, be);
    if (!wr) exp_rdv_q.push_back('{m: m, data: rd_val(addr)});
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (n < budget && (m0_cmds.size() != 0 || m1_cmds.size() != 0 ||
           exp_cmd_q.size() != 0 || exp_rdv_q.size() != 0 ||
           pend_q.size() != 0 || busy)) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
    end
    check(name, busy, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_avm_read", avm_read, 1'b0);
    check("rst_avm_write", avm_write, 1'b0);
    check("rst_m0_wait", m0_waitrequest, 1'b1);
    check("rst_m1_wait", m1_waitrequest, 1'b1);
    check("rst_m0_rdv", m0_readdatavalid, 1'b0);
    check("rst_m1_rdv", m1_readdatavalid, 1'b0);
    check("rst_owner", owner, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_err", err_rdv, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    int r_cyc;

    #2 reset_n = 1'b0;
    #21;
    check_reset_outputs();
    @(negedge clk);
    reset_n = 1'b1;

    // Both stream writes from the first cycle: m0 wins, 8-command bursts alternate.
    for (int i = 0; i < 16; i++) begin
      issue(1'b0, 1'b1, 32'h1000 + i, 32'hA000_0000 + i, 4'hF);
      issue(1'b1, 1'b1, 32'h2000 + i, 32'hB000_0000 + i, 4'h5);
    end
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 8; i++) expect_cmd(1'b1, 32'h1000 + b*8 + i, 32'hA000_0000 + b*8 + i, 4'hF);
      for (int i = 0; i < 8; i++) expect_cmd(1'b1, 32'h2000 + b*8 + i, 32'hB000_0000 + b*8 + i, 4'h5);
    end
    wait_done("alt_done", 200);
    check("alt_owner", owner, 1'b1);

    // m0 alone: 3 reads, returns 2 cycles after each accept, stalled slave.
    slave_stall = 1'b1;
    slave_lat   = 2;
    for (int i = 0; i < 3; i++) issue_exp(1'b0, 1'b0, 32'h3000 + 4*i, 32'h0, 4'hF);
    wait_done("rd3_done", 100);
    slave_stall = 1'b0;
    check("rd3_owner", owner, 1'b0);
    check("rd3_err", err_rdv, 1'b0);

    // Outstanding limit: 5 reads with returns held off, only 4 accepted.
    slave_hold = 1'b1;
    base = acc_cnt;
    for (int i = 0; i < 5; i++) issue_exp(1'b0, 1'b0, 32'h4000 + 4*i, 32'h0, 4'h3);
    n = 0;
    while (n < 30 && acc_cnt < base + 4) begin @(negedge clk); #1; n++; end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("lim_m0_wait", m0_waitrequest, 1'b1);
      check("lim_avm_read", avm_read, 1'b0);
      check("lim_accepts", acc_cnt - base, 4);
    end
    slave_hold = 1'b0;
    n = 0;
    while (n < 20 && !m0_readdatavalid) begin @(negedge clk); #1; n++; end
    r_cyc = cyc;
    n = 0;
    while (n < 20 && acc_cnt < base + 5) begin @(negedge clk); #1; n++; end
    check("lim_5th_cycle", last_acc_cyc, r_cyc + 1);
    wait_done("lim_done", 100);

    // Drain: m0 2 reads then drops, m1 waits until both returns reach m0.
    slave_lat = 4;
    base = acc_cnt;
    issue_exp(1'b0, 1'b0, 32'h5000, 32'h0, 4'hF);
    issue_exp(1'b0, 1'b0, 32'h5004, 32'h0, 4'hF);
    @(posedge clk);
    @(posedge clk);
    issue_exp(1'b1, 1'b1, 32'h6000, 32'hC0DE_0001, 4'hC);
    n = 0;
    while (n < 60 && acc_cnt < base + 3) begin
      @(negedge clk); #1; n++;
      if (exp_rdv_q.size() != 0) check("drain_m1_wait", m1_waitrequest, 1'b1);
    end
    check("drain_grant_cycle", last_acc_cyc, last_rdv_cyc + 2);
    wait_done("drain_done", 100);
    check("drain_owner", owner, 1'b1);

    // Stray return in IDLE: sticky error, no routing, counter stays 0.
    @(negedge clk); #1;
    check("err_before", err_rdv, 1'b0);
    inject_rdv = 1'b1;
    @(posedge clk); #2;
    inject_rdv = 1'b0;
    @(negedge clk); #1;
    check("err_no_m0_rdv", m0_readdatavalid, 1'b0);
    check("err_no_m1_rdv", m1_readdatavalid, 1'b0);
    @(negedge clk); #1;
    check("err_set", err_rdv, 1'b1);
    check("err_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    check("err_sticky", err_rdv, 1'b1);

    // Reset mid-GRANT with 2 reads outstanding for m1.
    slave_hold = 1'b1;
    slave_lat  = 1;
    base = acc_cnt;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b0, 32'h7000 + 4*i, 32'h0, 4'hF);
      expect_cmd(1'b0, 32'h7000 + 4*i, 32'h0, 4'hF);
    end
    n = 0;
    while (n < 30 && acc_cnt < base + 2) begin @(negedge clk); #1; n++; end
    @(posedge clk); #3;
    check("pre_rst_owner", owner, 1'b1);
    check("pre_rst_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    m1_cmds.delete();
    exp_cmd_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_owner", owner, 1'b0);
    check("post_rst_busy", busy, 1'b0);
    check("post_rst_m1_wait", m1_waitrequest, 1'b1);
    slave_hold = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("stale_rdv_err", err_rdv, 1'b1);
    check("stale_rdv_busy", busy, 1'b0);

    check("exp_cmd_left", exp_cmd_q.size(), 0);
    check("exp_rdv_left", exp_rdv_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
